// File: rtl/phase_mon_pkg.sv
// Shared types, phase codes and LED field positions for the four-phase sequence monitor.
package phase_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ERR    = 2'd2
  } mon_state_e;

  localparam logic [3:0] PH_T1 = 4'b0001;
  localparam logic [3:0] PH_T2 = 4'b0010;
  localparam logic [3:0] PH_T3 = 4'b0100;
  localparam logic [3:0] PH_T4 = 4'b1000;

  localparam int LED_CNT_LSB  = 0;
  localparam int LED_PH_LSB   = 8;
  localparam int LED_ERR_BIT  = 12;
  localparam int LED_LOCK_BIT = 13;

  function automatic logic is_onehot4(input logic [3:0] p);
    return (p != 4'b0000) && ((p & (p - 4'd1)) == 4'b0000);
  endfunction

  // T4 wraps back to T1.
  function automatic logic [3:0] next_phase(input logic [3:0] p);
    return {p[2:0], p[3]};
  endfunction

endpackage

// File: rtl/phase_sequence_monitor_pattern_filter.sv
// Two-flop synchronizer plus stability filter: a new pattern is accepted only after
// it has been seen unchanged long enough; new_pat_o strobes for the accepting cycle.
module pattern_filter #(
  parameter int WIDTH         = 4,
  parameter int FILTER_CYCLES = 10000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] accepted_o,
  output logic             new_pat_o
);

  localparam int             CW   = $clog2(FILTER_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] accepted_q;
  logic [WIDTH-1:0] candidate_q;
  logic [CW-1:0]    stab_cnt_q;
  logic             new_pat;

  assign new_pat = (sync2_q != accepted_q) && (sync2_q == candidate_q) && (stab_cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      accepted_q  <= '0;
      candidate_q <= '0;
      stab_cnt_q  <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      if (sync2_q == accepted_q) begin
        stab_cnt_q <= '0;
      end else if (sync2_q != candidate_q) begin
        candidate_q <= sync2_q;
        stab_cnt_q  <= '0;
      end else if (stab_cnt_q == LAST) begin
        accepted_q <= candidate_q;
        stab_cnt_q <= '0;
      end else begin
        stab_cnt_q <= stab_cnt_q + CW'(1);
      end
    end
  end

  // Present the pattern being accepted in the same cycle as the strobe.
  assign accepted_o = new_pat ? candidate_q : accepted_q;
  assign new_pat_o  = new_pat;

endmodule

// File: rtl/phase_sequence_monitor.sv
// Receives T1..T4 phase lines, checks rotation order, counts full rotations and
// drives count / phase / error / lock onto the 16 LEDs.
module phase_sequence_monitor
  import phase_mon_pkg::*;
#(
  parameter int FILTER_CYCLES = 10000,
  parameter int CNT_W         = 8
) (
  input  logic        sys_clk_in,
  input  logic        sys_rst_n,
  input  logic [3:0]  t_in,
  input  logic        clr_n,
  output logic [15:0] led_pin
);

  logic [3:0]       pat;
  logic             new_pat;
  logic             clr_meta_q;
  logic             clr_sync_q;
  mon_state_e       state_q;
  logic [3:0]       field_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;
  logic             lock_q;

  pattern_filter #(
    .WIDTH         (4),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_t_filter (
    .clk_i      (sys_clk_in),
    .rst_ni     (sys_rst_n),
    .din_i      (t_in),
    .accepted_o (pat),
    .new_pat_o  (new_pat)
  );

  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clr_meta_q <= 1'b1;
      clr_sync_q <= 1'b1;
    end else begin
      clr_meta_q <= clr_n;
      clr_sync_q <= clr_meta_q;
    end
  end

  // Clear dominates: a pattern accepted while clear is active is dropped.
  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      field_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else if (!clr_sync_q) begin
      state_q <= ST_IDLE;
      field_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else if (new_pat) begin
      case (state_q)
        ST_IDLE: begin
          if (pat == PH_T1) begin
            state_q <= ST_LOCKED;
            field_q <= PH_T1;
            lock_q  <= 1'b1;
          end else if ((pat != 4'b0000) && !is_onehot4(pat)) begin
            state_q <= ST_ERR;
            field_q <= pat;
            err_q   <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (pat == next_phase(field_q)) begin
            field_q <= pat;
            if (field_q == PH_T4) begin
              count_q <= count_q + CNT_W'(1);
            end
          end else if (pat == 4'b0000) begin
            state_q <= ST_IDLE;
            field_q <= '0;
            lock_q  <= 1'b0;
          end else begin
            state_q <= ST_ERR;
            field_q <= pat;
            err_q   <= 1'b1;
            lock_q  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    led_pin                          = '0;
    led_pin[LED_CNT_LSB +: 8]        = 8'(count_q);
    led_pin[LED_PH_LSB +: 4]         = field_q;
    led_pin[LED_ERR_BIT]             = err_q;
    led_pin[LED_LOCK_BIT]            = lock_q;
  end

endmodule

// File: tb/tb_phase_sequence_monitor.sv
// Directed and randomized checks of phase_sequence_monitor against a rotation-level model.
module tb_phase_sequence_monitor;

  localparam int FC = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_n = 1'b1;
  logic [3:0]  t_in  = 4'b0000;
  logic [15:0] led;

  int checks = 0;
  int errors = 0;

  // Model: last accepted pattern, lock/error flags, phase index 0..3, total rotations.
  logic [3:0] m_acc   = 4'b0000;
  bit         m_lock  = 1'b0;
  bit         m_err   = 1'b0;
  int         m_idx   = 0;
  logic [3:0] m_bad   = 4'b0000;
  int         m_rot   = 0;

  always #5 clk = ~clk;

  phase_sequence_monitor #(
    .FILTER_CYCLES (FC),
    .CNT_W         (8)
  ) dut (
    .sys_clk_in (clk),
    .sys_rst_n  (rst_n),
    .t_in       (t_in),
    .clr_n      (clr_n),
    .led_pin    (led)
  );

  function automatic logic [15:0] model_led();
    logic [3:0] field;
    field = m_lock ? 4'(1 << m_idx) : (m_err ? m_bad : 4'b0000);
    return {2'b00, m_lock, m_err, field, 8'(m_rot % 256)};
  endfunction

  task automatic check(input string tag, input logic [15:0] exp);
    checks++;
    assert (led === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, led, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check(tag, model_led());
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_apply(input logic [3:0] p);
    logic [3:0] want;
    if (p == m_acc) return;
    m_acc = p;
    if (m_err) return;
    if (m_lock) begin
      want = 4'(1 << ((m_idx + 1) % 4));
      if (p == want) begin
        m_idx = (m_idx + 1) % 4;
        if (m_idx == 0) m_rot++;
      end else if (p == 4'b0000) begin
        m_lock = 1'b0;
      end else begin
        m_lock = 1'b0;
        m_err  = 1'b1;
        m_bad  = p;
      end
    end else begin
      if (p == 4'b0001) begin
        m_lock = 1'b1;
        m_idx  = 0;
      end else if ($countones(p) > 1) begin
        m_err = 1'b1;
        m_bad = p;
      end
    end
  endtask

  task automatic m_clear();
    m_lock = 1'b0;
    m_err  = 1'b0;
    m_rot  = 0;
  endtask

  task automatic hold(input logic [3:0] p, input int n, input string tag);
    t_in = p;
    cyc(n);
    if (n >= FC + 3) m_apply(p);
    check_model(tag);
  endtask

  task automatic do_clear(input int n);
    clr_n = 1'b0;
    cyc(n);
    clr_n = 1'b1;
    cyc(3);
    m_clear();
    check_model("clear");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [3:0] p;
    int r, n;

    // Reset state
    cyc(3);
    check("reset_led", 16'h0000);
    rst_n = 1'b1;
    cyc(2);
    check("post_reset", 16'h0000);

    // 1: first T1 lands exactly FC+3 edges after the change, then one rotation
    t_in = 4'b0001;
    cyc(FC + 2);
    check("lat_before", 16'h0000);
    cyc(1);
    check("lat_after", 16'h2100);
    cyc(3);
    m_apply(4'b0001);
    hold(4'b0010, 10, "t1_t2");
    hold(4'b0100, 10, "t1_t3");
    hold(4'b1000, 10, "t1_t4");
    hold(4'b0001, 10, "t1_wrap");
    check("t1_one_rot", 16'h2101);

    // 2: 300 rotations from a clean count, passing through the 8-bit wrap
    do_clear(5);
    hold(4'b0000, 10, "t2_stop");
    for (int i = 0; i < 300; i++) begin
      hold(4'b0001, 10, "t2_p1");
      hold(4'b0010, 10, "t2_p2");
      hold(4'b0100, 10, "t2_p3");
      hold(4'b1000, 10, "t2_p4");
    end
    hold(4'b0001, 10, "t2_last");
    check("t2_count44", 16'h212C);

    // 3: short multi-hot glitch ignored, sustained one goes to error
    hold(4'b0010, 10, "t3_t2");
    hold(4'b0110, 3, "t3_glitch");
    hold(4'b0010, 10, "t3_back");
    check("t3_still_lock", 16'h222C);
    hold(4'b0110, 10, "t3_multi");
    check("t3_err", 16'h162C);

    // 4: skip error, clear latency, relock
    do_clear(5);
    hold(4'b0001, 10, "t4_lock");
    hold(4'b0100, 10, "t4_skip");
    check("t4_err", 16'h1400);
    clr_n = 1'b0;
    cyc(2);
    check_model("t4_clr_pre");
    cyc(1);
    m_clear();
    check("t4_clr_post", 16'h0000);
    cyc(2);
    clr_n = 1'b1;
    cyc(3);
    check_model("t4_clr_rel");
    hold(4'b0001, 10, "t4_relock");
    check("t4_relock_cnt0", 16'h2100);

    // 5: generator stop keeps count, wait for T1
    hold(4'b0010, 10, "t5_a");
    hold(4'b0100, 10, "t5_b");
    hold(4'b1000, 10, "t5_c");
    hold(4'b0001, 10, "t5_d");
    hold(4'b0010, 10, "t5_e");
    hold(4'b0100, 10, "t5_f");
    hold(4'b0000, 10, "t5_stop");
    check("t5_idle_cnt", 16'h0001);
    hold(4'b0010, 10, "t5_wait_t1");
    check("t5_still_idle", 16'h0001);
    hold(4'b0001, 10, "t5_lock");
    check("t5_locked", 16'h2101);

    // Randomized segments against the model
    for (int s = 0; s < 200; s++) begin
      r = int'($urandom_range(0, 99));
      n = int'($urandom_range(8, 14));
      if (r < 5) begin
        do_clear(4);
      end else begin
        if (r < 75) p = ($countones(t_in) == 1) ? {t_in[2:0], t_in[3]} : 4'b0001;
        else if (r < 80) p = 4'b0000;
        else if (r < 85) p = 4'b0001;
        else p = 4'($urandom);
        hold(p, n, "rand");
      end
    end

    // 6a: asynchronous reset in the middle of T3
    do_clear(4);
    hold(4'b0000, 10, "t6_stop");
    hold(4'b0001, 10, "t6_t1");
    hold(4'b0010, 10, "t6_t2");
    hold(4'b0100, 10, "t6_t3");
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    m_acc = 4'b0000;
    m_clear();
    check("t6_rst_immediate", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    hold(4'b0100, 10, "t6_t3_after_rst");
    check("t6_idle_after_rst", 16'h0000);
    hold(4'b0001, 10, "t6_relock");
    check("t6_relocked", 16'h2100);

    // 6b: clear coincides with the T4->T1 acceptance
    hold(4'b0010, 10, "t6_b2");
    hold(4'b0100, 10, "t6_b3");
    hold(4'b1000, 10, "t6_b4");
    t_in = 4'b0001;
    cyc(FC);
    clr_n = 1'b0;
    cyc(1);
    clr_n = 1'b1;
    cyc(5);
    m_clear();
    m_acc = 4'b0001;
    check("t6_clr_wins", 16'h0000);
    hold(4'b0010, 10, "t6_after_clr");
    check("t6_idle_kept", 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
